cry_encoder: RTL and testbench

- Sequential RGB-to-CRY colour encoder, the inverse of the cry_r/cry_g/cry_b chroma lookup ROMs.
- Accepts one 24-bit RGB pixel and sets intensity Y = max(R,G,B).
- Scans all 256 chroma entries through the existing ROMs and returns the 16-bit CRY word {chroma index, Y} with minimum reconstruction error.
- Drives the ROM address itself and consumes the registered ROM outputs. Used by the test/tooling path that turns RGB images into CRY framebuffers.

---
 rtl/cry_encoder_pkg.sv | 33 +++
 rtl/cry_err_calc.sv | 33 +++
 rtl/cry_encoder.sv | 134 +++++++++++++
 tb/tb_cry_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cry_encoder_pkg.sv
// Shared widths, FSM states and helpers for the RGB-to-CRY encoder.
package cry_encoder_pkg;

  localparam int CHROMA_W = 8;
  localparam int INT_W    = 8;
  localparam int CRY_W    = CHROMA_W + INT_W;
  localparam int PROD_W   = 16;
  localparam int TERM_W   = 16;
  localparam int ERR_W    = 18;
  localparam int NUM_COMP = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [INT_W-1:0] r;
    logic [INT_W-1:0] g;
    logic [INT_W-1:0] b;
  } rgb_t;

  function automatic logic [INT_W-1:0] max3(input logic [INT_W-1:0] a,
                                            input logic [INT_W-1:0] b,
                                            input logic [INT_W-1:0] c);
    logic [INT_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cry_err_calc.sv
// One colour component of the reconstruction error: registered |t*Y - 255*C|.
module cry_err_calc
  import cry_encoder_pkg::*;
(
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic [INT_W-1:0]  t,
  input  logic [INT_W-1:0]  y,
  input  logic [INT_W-1:0]  c,
  output logic [TERM_W-1:0] term
);

  localparam logic [PROD_W-1:0] SCALE = PROD_W'(255);

  logic [PROD_W-1:0]        ty;
  logic [PROD_W-1:0]        kc;
  logic signed [PROD_W:0]   diff;
  logic [TERM_W-1:0]        mag;

  // Both products fit 16 bits unsigned; the 17-bit signed difference never overflows.
  always_comb begin
    ty   = PROD_W'(t) * PROD_W'(y);
    kc   = SCALE * PROD_W'(c);
    diff = $signed({1'b0, ty}) - $signed({1'b0, kc});
    mag  = diff[PROD_W] ? TERM_W'(-diff) : TERM_W'(diff);
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) term <= '0;
    else         term <= mag;
  end

endmodule

// File: rtl/cry_encoder.sv
// Sequential RGB-to-CRY encoder: sweeps all chroma ROM entries and keeps the
// index with minimum reconstruction error at intensity Y = max(R,G,B).
module cry_encoder
  import cry_encoder_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                sys_clk,
  input  logic                resetl,
  input  logic                start,
  input  logic [INT_W-1:0]    r,
  input  logic [INT_W-1:0]    g,
  input  logic [INT_W-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [CRY_W-1:0]    cry,
  output logic [CHROMA_W-1:0] rom_a,
  input  logic [INT_W-1:0]    rom_r,
  input  logic [INT_W-1:0]    rom_g,
  input  logic [INT_W-1:0]    rom_b
);

  // vld_pipe[ROM_LAT-1] marks ROM data, vld_pipe[STAGES] marks error terms.
  localparam int STAGES = ROM_LAT;

  state_e                              state;
  rgb_t                                pix;
  logic [INT_W-1:0]                    y_lat;
  logic [INT_W-1:0]                    y_in;
  logic                                accept;

  logic [STAGES:0]                     vld_pipe;
  logic [STAGES:0][CHROMA_W-1:0]       idx_pipe;

  logic [NUM_COMP-1:0][INT_W-1:0]      t_vec;
  logic [NUM_COMP-1:0][INT_W-1:0]      c_vec;
  logic [NUM_COMP-1:0][TERM_W-1:0]     term_vec;

  logic [ERR_W-1:0]                    err_sum;
  logic [ERR_W-1:0]                    best_err;
  logic [CHROMA_W-1:0]                 best_idx;
  logic                                cmp_last;

  assign y_in   = max3(r, g, b);
  assign accept = (state == IDLE) && start;

  assign t_vec = {rom_b, rom_g, rom_r};
  assign c_vec = {pix.b, pix.g, pix.r};

  for (genvar k = 0; k < NUM_COMP; k++) begin : g_comp
    cry_err_calc u_err (
      .sys_clk (sys_clk),
      .resetl  (resetl),
      .t       (t_vec[k]),
      .y       (y_lat),
      .c       (c_vec[k]),
      .term    (term_vec[k])
    );
  end

  always_comb begin
    err_sum = '0;
    for (int k = 0; k < NUM_COMP; k++) err_sum = err_sum + ERR_W'(term_vec[k]);
  end

  // Address tagging and the running minimum; strict '<' keeps the lowest index on ties.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      best_err <= '1;
      best_idx <= '0;
      cmp_last <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == SCAN};
      idx_pipe <= {idx_pipe[STAGES-1:0], rom_a};
      cmp_last <= vld_pipe[STAGES] && (idx_pipe[STAGES] == '1);
      if (accept) begin
        best_err <= '1;
        best_idx <= '0;
      end else if (vld_pipe[STAGES] && (err_sum < best_err)) begin
        best_err <= err_sum;
        best_idx <= idx_pipe[STAGES];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cry   <= '0;
      rom_a <= '0;
      pix   <= '0;
      y_lat <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pix   <= '{r: r, g: g, b: b};
            y_lat <= y_in;
            if (y_in == '0) begin
              // Black needs no search: every chroma reconstructs to zero.
              state <= DONE;
              done  <= 1'b1;
              cry   <= '0;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
              rom_a <= '0;
            end
          end
        end
        SCAN: begin
          if (rom_a == '1) state <= DRAIN;
          else             rom_a <= rom_a + 1'b1;
        end
        DRAIN: begin
          if (cmp_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cry   <= {best_idx, y_lat};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cry_encoder.sv
// Bench for cry_encoder: registered ROM models and a brute-force reference search.
module tb_cry_encoder;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        start;
  logic [7:0]  r, g, b;
  logic        busy, done;
  logic [15:0] cry;
  logic [7:0]  rom_a;
  logic [7:0]  rom_r, rom_g, rom_b;

  logic [7:0]  tr [256];
  logic [7:0]  tg [256];
  logic [7:0]  tb [256];

  int checks = 0;
  int errors = 0;

  cry_encoder #(.ROM_LAT(1)) dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .start   (start),
    .r       (r),
    .g       (g),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .cry     (cry),
    .rom_a   (rom_a),
    .rom_r   (rom_r),
    .rom_g   (rom_g),
    .rom_b   (rom_b)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    rom_r <= tr[rom_a];
    rom_g <= tg[rom_a];
    rom_b <= tb[rom_a];
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Exhaustive search over the chroma table using plain integer arithmetic.
  function automatic logic [15:0] ref_cry(input int rr, input int gg, input int bb);
    int y, best, bi, e;
    y = rr;
    if (gg > y) y = gg;
    if (bb > y) y = bb;
    if (y == 0) return 16'h0000;
    best = 32'h7fffffff;
    bi   = 0;
    for (int i = 0; i < 256; i++) begin
      e = iabs(int'(tr[i]) * y - 255 * rr) + iabs(int'(tg[i]) * y - 255 * gg)
        + iabs(int'(tb[i]) * y - 255 * bb);
      if (e < best) begin
        best = e;
        bi   = i;
      end
    end
    return 16'((bi << 8) | y);
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) begin
      tr[i] = 8'(i);
      tg[i] = 8'(255 - i);
      tb[i] = 8'd128;
    end
  endtask

  // Leaves the caller #1 after the accept edge (edge 0).
  task automatic start_req(input logic [7:0] rr, input logic [7:0] gg,
                           input logic [7:0] bb, input bit hold);
    @(posedge sys_clk); #1;
    r = rr; g = gg; b = bb; start = 1'b1;
    @(posedge sys_clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Steps edges until done; reports the edge number and how many samples saw busy.
  task automatic wait_done(input int max_n, output int edge_n, output int busy_hi);
    edge_n  = -1;
    busy_hi = 0;
    for (int n = 0; n <= max_n; n++) begin
      if (n > 0) begin @(posedge sys_clk); #1; end
      if (done) begin
        edge_n = n;
        break;
      end
      if (busy) busy_hi++;
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0; start = 1'b0; r = '0; g = '0; b = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cry !== 16'h0000) begin errors++; $display("FAIL reset_cry: got %h expected 0000", cry); end
    checks++; if (rom_a !== 8'h00) begin errors++; $display("FAIL reset_rom_a: got %h expected 00", rom_a); end
    resetl = 1'b1;
  endtask

  task automatic test_zero();
    int late_done, moved;
    load_ramp();
    start_req(8'd0, 8'd0, 8'd0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (cry !== ref_cry(0, 0, 0)) begin errors++; $display("FAIL zero_cry: got %h expected %h", cry, ref_cry(0, 0, 0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    late_done = 0; moved = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge sys_clk); #1;
      if (done) late_done++;
      if (rom_a !== 8'h00) moved++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL zero_single_pulse: got %0d extra pulses expected 0", late_done); end
    checks++; if (moved != 0) begin errors++; $display("FAIL zero_rom_a: got %0d cycles off 00 expected 0", moved); end
  endtask

  task automatic test_ramp();
    int en, bh;
    logic [15:0] exp_c;
    load_ramp();
    exp_c = ref_cry(255, 0, 128);
    start_req(8'd255, 8'd0, 8'd128, 1'b0);
    wait_done(300, en, bh);
    checks++; if (en != 259) begin errors++; $display("FAIL ramp_latency: got edge %0d expected 259", en); end
    checks++; if (bh != 259) begin errors++; $display("FAIL ramp_busy_span: got %0d busy cycles expected 259", bh); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_drop: got %b expected 0", busy); end
    checks++; if (cry !== 16'hFFFF || cry !== exp_c) begin errors++; $display("FAIL ramp_cry: got %h expected FFFF model %h", cry, exp_c); end
    checks++; if (rom_a !== 8'hFF) begin errors++; $display("FAIL ramp_rom_a_hold: got %h expected FF", rom_a); end
    @(posedge sys_clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_width: got %b expected 0", done); end
    exp_c = ref_cry(0, 255, 128);
    start_req(8'd0, 8'd255, 8'd128, 1'b0);
    checks++; if (rom_a !== 8'h00) begin errors++; $display("FAIL ramp_rom_a_restart: got %h expected 00", rom_a); end
    wait_done(300, en, bh);
    checks++; if (en != 259) begin errors++; $display("FAIL ramp2_latency: got edge %0d expected 259", en); end
    checks++; if (cry !== 16'h00FF || cry !== exp_c) begin errors++; $display("FAIL ramp2_cry: got %h expected 00FF model %h", cry, exp_c); end
  endtask

  task automatic test_tie();
    int en, bh;
    for (int i = 0; i < 256; i++) begin
      tr[i] = 8'd100; tg[i] = 8'd100; tb[i] = 8'd100;
    end
    start_req(8'd200, 8'd200, 8'd200, 1'b0);
    wait_done(300, en, bh);
    checks++; if (en != 259) begin errors++; $display("FAIL tie_latency: got edge %0d expected 259", en); end
    checks++; if (cry !== 16'h00C8) begin errors++; $display("FAIL tie_cry: got %h expected 00C8", cry); end
  endtask

  task automatic test_random();
    int en, bh;
    logic [7:0] rr, gg, bb;
    logic [15:0] exp_c;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 256; i++) begin
        tr[i] = 8'($urandom); tg[i] = 8'($urandom); tb[i] = 8'($urandom);
      end
      rr = 8'($urandom_range(1, 255));
      gg = 8'($urandom_range(0, (it < 4) ? 255 : 40));
      bb = 8'($urandom_range(0, 255));
      exp_c = ref_cry(int'(rr), int'(gg), int'(bb));
      start_req(rr, gg, bb, 1'b0);
      wait_done(300, en, bh);
      checks++; if (en != 259) begin errors++; $display("FAIL rand_latency[%0d]: got edge %0d expected 259", it, en); end
      checks++; if (cry !== exp_c) begin errors++; $display("FAIL rand_cry[%0d] rgb=%h%h%h: got %h expected %h", it, rr, gg, bb, cry, exp_c); end
    end
  endtask

  task automatic test_start_ignored();
    int first, cnt;
    logic [15:0] got;
    load_ramp();
    start_req(8'd255, 8'd0, 8'd128, 1'b0);
    first = -1; cnt = 0; got = '0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge sys_clk); #1;
      if (done) begin
        cnt++;
        if (first < 0) begin first = n; got = cry; end
      end
      if (n == 49) begin start = 1'b1; r = '0; g = '0; b = '0; end
      if (n == 50) start = 1'b0;
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL ignore_pulses: got %0d done pulses expected 1", cnt); end
    checks++; if (first != 259) begin errors++; $display("FAIL ignore_latency: got edge %0d expected 259", first); end
    checks++; if (got !== 16'hFFFF) begin errors++; $display("FAIL ignore_cry: got %h expected FFFF", got); end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    logic [15:0] c0, c1;
    load_ramp();
    start_req(8'd255, 8'd0, 8'd128, 1'b1);
    r = 8'd0; g = 8'd255; b = 8'd128;
    d0 = -1; d1 = -1; c0 = '0; c1 = '0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge sys_clk); #1;
      if (done) begin
        if (d0 < 0) begin d0 = n; c0 = cry; end
        else begin d1 = n; c1 = cry; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    checks++; if (d0 != 259) begin errors++; $display("FAIL b2b_first_edge: got %0d expected 259", d0); end
    checks++; if (c0 !== 16'hFFFF) begin errors++; $display("FAIL b2b_first_cry: got %h expected FFFF", c0); end
    checks++; if (d1 != 520) begin errors++; $display("FAIL b2b_second_edge: got %0d expected 520", d1); end
    checks++; if (c1 !== 16'h00FF) begin errors++; $display("FAIL b2b_second_cry: got %h expected 00FF", c1); end
  endtask

  task automatic test_reset_mid();
    int en, bh, stray;
    load_ramp();
    start_req(8'd255, 8'd0, 8'd128, 1'b0);
    repeat (120) @(posedge sys_clk);
    #1;
    checks++; if (rom_a !== 8'd120 || busy !== 1'b1) begin errors++; $display("FAIL mid_progress: got rom_a=%h busy=%b expected 78/1", rom_a, busy); end
    resetl = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (cry !== 16'h0000) begin errors++; $display("FAIL mid_reset_cry: got %h expected 0000", cry); end
    checks++; if (rom_a !== 8'h00) begin errors++; $display("FAIL mid_reset_rom_a: got %h expected 00", rom_a); end
    stray = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge sys_clk); #1;
      if (done) stray++;
    end
    resetl = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge sys_clk); #1;
      if (done || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_done: got %0d stray cycles expected 0", stray); end
    start_req(8'd0, 8'd255, 8'd128, 1'b0);
    wait_done(300, en, bh);
    checks++; if (en != 259) begin errors++; $display("FAIL mid_restart_latency: got edge %0d expected 259", en); end
    checks++; if (cry !== 16'h00FF) begin errors++; $display("FAIL mid_restart_cry: got %h expected 00FF", cry); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_ramp();
    test_tie();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
